// File: rtl/uart_parity_unit.sv
// UART parity engine: TX parity generation for captured words and RX bit-serial
// parity accumulation with mismatch flagging and a saturating error counter.
module uart_parity_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = $clog2(DATA_WIDTH + 1),
   parameter int ERR_CNT_W  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  Busy,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_MODE,
   input  logic [LEN_W-1:0]      DATA_LEN,
   output logic                  tx_par_bit,
   output logic                  tx_par_valid,
   input  logic                  rx_frame_start,
   input  logic                  rx_bit_strobe,
   input  logic                  rx_bit,
   input  logic                  rx_clr_cnt,
   output logic                  rx_par_err,
   output logic                  rx_frame_done,
   output logic [ERR_CNT_W-1:0]  rx_err_cnt
);

   localparam logic [LEN_W-1:0]     MIN_LEN = LEN_W'(5);
   localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(DATA_WIDTH);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PAR
   } rx_state_t;

   // Mode 00 even, 01 odd, 10 mark, 11 space; xor_in is the XOR of the used bits.
   function automatic logic f_parity(input logic xor_in, input logic [1:0] mode);
      case (mode)
         2'b00:   return xor_in;
         2'b01:   return ~xor_in;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic [LEN_W-1:0]      w_len;
   logic [DATA_WIDTH-1:0] w_mask;
   logic                  w_tx_xor;
   logic [LEN_W-1:0]      w_cnt_inc;

   logic                  r_tx_par_bit;
   logic                  r_tx_par_valid;

   rx_state_t             r_state;
   logic                  r_acc;
   logic [LEN_W-1:0]      r_cnt;
   logic                  r_par_en;
   logic [1:0]            r_mode;
   logic [LEN_W-1:0]      r_len;
   logic                  r_par_err;
   logic                  r_frame_done;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   always_comb begin
      if (DATA_LEN < MIN_LEN)
         w_len = MIN_LEN;
      else if (DATA_LEN > MAX_LEN)
         w_len = MAX_LEN;
      else
         w_len = DATA_LEN;
   end

   always_comb begin
      for (int i = 0; i < DATA_WIDTH; i++)
         w_mask[i] = (i < int'(w_len));
      w_tx_xor = ^(P_DATA & w_mask);
   end

   assign w_cnt_inc = r_cnt + LEN_W'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tx_par_bit   <= 1'b0;
         r_tx_par_valid <= 1'b0;
      end else if (Data_Valid && !Busy) begin
         r_tx_par_bit   <= PAR_EN ? f_parity(w_tx_xor, PAR_MODE) : 1'b0;
         r_tx_par_valid <= 1'b1;
      end
   end

   // A frame start restarts the FSM from any state; the error-counter clear overrides
   // any increment made in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_acc        <= 1'b0;
         r_cnt        <= '0;
         r_par_en     <= 1'b0;
         r_mode       <= 2'b00;
         r_len        <= MIN_LEN;
         r_par_err    <= 1'b0;
         r_frame_done <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_par_err    <= 1'b0;
         r_frame_done <= 1'b0;
         if (rx_frame_start) begin
            r_state  <= S_DATA;
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_par_en <= PAR_EN;
            r_mode   <= PAR_MODE;
            r_len    <= w_len;
         end else begin
            case (r_state)
               S_DATA: begin
                  if (rx_bit_strobe) begin
                     r_acc <= r_acc ^ rx_bit;
                     r_cnt <= w_cnt_inc;
                     if (w_cnt_inc == r_len) begin
                        if (r_par_en) begin
                           r_state <= S_PAR;
                        end else begin
                           r_frame_done <= 1'b1;
                           r_state      <= S_IDLE;
                        end
                     end
                  end
               end
               S_PAR: begin
                  if (rx_bit_strobe) begin
                     if (rx_bit != f_parity(r_acc, r_mode)) begin
                        r_par_err <= 1'b1;
                        if (r_err_cnt != CNT_MAX)
                           r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                     end
                     r_frame_done <= 1'b1;
                     r_state      <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
         if (rx_clr_cnt)
            r_err_cnt <= '0;
      end
   end

   assign tx_par_bit    = r_tx_par_bit;
   assign tx_par_valid  = r_tx_par_valid;
   assign rx_par_err    = r_par_err;
   assign rx_frame_done = r_frame_done;
   assign rx_err_cnt    = r_err_cnt;

endmodule

// File: doc/uart_parity_unit.md
# uart_parity_unit

Parametrised parity engine for the UART serial path: a TX section that captures a data word and produces its parity bit, and an RX section that accumulates parity bit-by-bit from the deserialiser and flags mismatches. It supports runtime data length (5..DATA_WIDTH) and four parity modes (even/odd/mark/space). It sits between the UART register/config block and the TX serialiser / RX deserialiser, and replaces the fixed 8-bit even/odd parity calculator.

## Interface
- DATA_WIDTH, 8, maximum data bits per frame (5..9)
- LEN_W, $clog2(DATA_WIDTH+1), width of DATA_LEN
- ERR_CNT_W, 8, width of saturating RX parity-error counter
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  reset; synchronous, active-high
- P_DATA  input  DATA_WIDTH  TX parallel data
- Data_Valid  input  1  TX data qualifier
- Busy  input  1  serialiser busy; capture blocked while high
- PAR_EN  input  1  parity enable
- PAR_MODE  input  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- DATA_LEN  input  LEN_W  data bits per frame; <5 treated as 5, >DATA_WIDTH as DATA_WIDTH
- tx_par_bit  output  1  parity bit for last captured word
- tx_par_valid  output  1  high once a word has been captured since reset
- rx_frame_start  input  1  pulse: new RX frame begins
- rx_bit_strobe  input  1  pulse: rx_bit is a valid sampled bit
- rx_bit  input  1  sampled serial bit
- rx_clr_cnt  input  1  clear error counter
- rx_par_err  output  1  one-cycle pulse on parity mismatch
- rx_frame_done  output  1  one-cycle pulse at end of data/parity phase
- rx_err_cnt  output  ERR_CNT_W  saturating mismatch count

## Operation
- Reset (RST=1 at edge): tx_par_bit=0, tx_par_valid=0, rx_par_err=0, rx_frame_done=0, rx_err_cnt=0, RX FSM to IDLE, accumulator and bit counter 0.
- Effective length L = clamp(DATA_LEN, 5, DATA_WIDTH); only P_DATA[L-1:0] contributes.
- Expected parity: even = XOR of used bits; odd = its inverse; mark = 1; space = 0.
- TX: capture when Data_Valid && !Busy. On that edge tx_par_bit <= parity(P_DATA, L, PAR_MODE) using config sampled at the same edge; tx_par_valid <= 1. If PAR_EN=0 at capture, tx_par_bit <= 0. Otherwise tx_par_bit holds.
- RX FSM states IDLE, DATA, PAR:
  - any state, rx_frame_start: acc<=0, cnt<=0, latch PAR_EN/PAR_MODE/L, go DATA; aborts any frame in progress with no err/done pulse; a coincident rx_bit_strobe is ignored.
  - DATA, strobe: acc ^= rx_bit, cnt++; on the L-th bit go PAR if latched PAR_EN, else pulse rx_frame_done and go IDLE.
  - PAR, strobe: compare rx_bit with expected (from acc and latched mode); mismatch -> rx_par_err pulse, rx_err_cnt++ (saturates at all-ones); always pulse rx_frame_done, go IDLE.
  - IDLE: strobes ignored.
- rx_clr_cnt sets rx_err_cnt to 0; if coincident with an increment, clear wins.
- Config changes mid-frame do not affect the RX frame in progress.

## Timing
- TX latency: tx_par_bit valid at the first edge after capture cycle (1 cycle); stable until next capture.
- RX: rx_par_err/rx_frame_done registered, asserted the cycle after the final strobe, high exactly one cycle.
- Back-to-back: rx_frame_start in the cycle after the parity strobe is accepted; no dead cycle required.
- Strobes may be consecutive cycles; each strobe consumes exactly one bit.

## Test plan
- Reset then TX: P_DATA=0x5A, L=8, mode even, Data_Valid=1, Busy=0 -> next cycle tx_par_bit=0, tx_par_valid=1; repeat with odd -> 1; mark -> 1; space -> 0.
- Length masking: P_DATA=0xE1, DATA_LEN=5, even -> parity of 0x01 = 1; DATA_LEN=3 treated as 5 -> same; Busy=1 during Data_Valid -> tx_par_bit unchanged.
- RX good frame: start, 8 strobes of 0xA5 LSB-first, even, parity strobe rx_bit=0 -> rx_frame_done pulse, no rx_par_err, rx_err_cnt=0.
- RX bad parity: same frame with parity bit 1 -> rx_par_err pulse one cycle after strobe, rx_err_cnt=1; PAR_EN=0 frame -> rx_frame_done after 8th bit, no error.
- Abort/simultaneity: rx_frame_start after 4 bits, coincident strobe -> strobe ignored, no pulses; new full frame checks correctly.
- Counter: ERR_CNT_W=2, force 5 errors -> rx_err_cnt sticks at 3; rx_clr_cnt coincident with error -> 0; RST mid-frame -> all outputs 0, FSM IDLE.
